sevenseg_scan_display: RTL and testbench

Multi-digit, time-multiplexed seven-segment display driver, the parametrised successor to the adder's single-digit segment decoder. It accepts a W-bit unsigned binary value on a load strobe and converts it to BCD with a sequential double-dabble engine. It then scans N_DIGITS common-anode digits at a prescaled refresh rate. It sits between the arithmetic datapath (adder/ALU result) and the board's segment/anode pins.

---
 rtl/sevenseg_pkg.sv | 28 ++
 rtl/seg7_bcd_decode.sv | 30 +++
 rtl/sevenseg_scan_display.sv | 138 +++++++++++++
 tb/tb_sevenseg_scan_display.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared segment patterns, FSM state type and BCD sizing helper for the scanned display.
// Patterns are active-low {a,b,c,d,e,f,g}.
package sevenseg_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    function automatic int bcd_width(input int n_digits);
        return 4 * n_digits;
    endfunction

endpackage

// File: rtl/seg7_bcd_decode.sv
// Combinational BCD nibble to active-low seven-segment pattern, with a blanking override.
module seg7_bcd_decode
    import sevenseg_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    // Codes 10-15 never come out of the double-dabble engine; they show blank.
    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/sevenseg_scan_display.sv
// Binary-to-BCD (sequential double dabble) plus time-multiplexed common-anode digit scan.
// Optional: define SEVENSEG_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module sevenseg_scan_display
    import sevenseg_pkg::*;
#(
    parameter int W        = 8,
    parameter int N_DIGITS = 4,
    parameter int CLK_DIV  = 50000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [W-1:0]        value,
    output logic                busy,
    output logic                ovf,
    output logic [6:0]          seg,
    output logic [N_DIGITS-1:0] an
);

    localparam int BW = bcd_width(N_DIGITS);
    localparam int CW = $clog2(W + 1);
    localparam int PW = $clog2(CLK_DIV);
    localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    state_t          state, next_state;
    logic [W-1:0]    bin_q;
    logic [BW-1:0]   bcd_q;
    logic [BW-1:0]   bcd_adj;
    logic [BW-1:0]   disp_q;
    logic            ovf_work;
    logic [CW-1:0]   iter;
    logic [PW-1:0]   presc;
    logic [DW-1:0]   digit_idx;
    logic [3:0]      cur_nibble;
    logic            blank;
    logic [6:0]      dec_seg;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (load) next_state = SHIFT;
            SHIFT:   if (iter == CW'(1)) next_state = COMMIT;
            COMMIT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    // The display register and ovf only move together at COMMIT, so the scan never shows a half-converted value.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q    <= '0;
            bcd_q    <= '0;
            ovf_work <= 1'b0;
            iter     <= '0;
            disp_q   <= '0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        bin_q    <= value;
                        bcd_q    <= '0;
                        ovf_work <= 1'b0;
                        iter     <= CW'(W);
                    end
                end
                SHIFT: begin
                    bcd_q <= {bcd_adj[BW-2:0], bin_q[W-1]};
                    bin_q <= bin_q << 1;
                    if (bcd_adj[BW-1]) ovf_work <= 1'b1;
                    iter  <= iter - CW'(1);
                end
                COMMIT: begin
                    disp_q <= bcd_q;
                    ovf    <= ovf_work;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc     <= '0;
            digit_idx <= '0;
        end else if (presc == PW'(CLK_DIV - 1)) begin
            presc     <= '0;
            digit_idx <= (digit_idx == DW'(N_DIGITS - 1)) ? '0 : digit_idx + DW'(1);
        end else begin
            presc <= presc + PW'(1);
        end
    end

    assign cur_nibble = disp_q[4*int'(digit_idx) +: 4];

`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
    // Blank when this digit and everything above it is zero; digit 0 always shows.
    always_comb begin
        blank = (digit_idx != '0);
        for (int i = 0; i < N_DIGITS; i++) begin
            if (i >= int'(digit_idx) && disp_q[4*i +: 4] != 4'd0) blank = 1'b0;
        end
    end
`else
    assign blank = 1'b0;
`endif

    seg7_bcd_decode u_decode (
        .bcd   (cur_nibble),
        .blank (blank),
        .seg   (dec_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= SEG_BLANK;
            an  <= '1;
        end else begin
            seg <= ovf ? SEG_DASH : dec_seg;
            an  <= ~(N_DIGITS'(1) << digit_idx);
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_display.sv
// Self-checking bench: two instances (4 digits and 2 digits), decimal reference model, scan-position model.
// Honours SEVENSEG_LEADING_ZERO_BLANK_EN in the model when the macro is defined.
module tb_sevenseg_scan_display;

    localparam int W       = 8;
    localparam int N1      = 4;
    localparam int N2      = 2;
    localparam int CLK_DIV = 4;

    logic          clk;
    logic          rst;
    logic          load1, load2;
    logic [W-1:0]  value1, value2;
    logic          busy1, busy2, ovf1, ovf2;
    logic [6:0]    seg1, seg2;
    logic [N1-1:0] an1;
    logic [N2-1:0] an2;

    int total_checks  = 0;
    int passed_checks = 0;
    int failed_checks = 0;
    int cyc = 0;
    int n;

    int model_val1 = 0, model_val2 = 0;
    bit model_ovf1 = 0, model_ovf2 = 0;

    logic [6:0] seg_table [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                   7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    sevenseg_scan_display #(.W(W), .N_DIGITS(N1), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst(rst), .load(load1), .value(value1),
        .busy(busy1), .ovf(ovf1), .seg(seg1), .an(an1)
    );

    sevenseg_scan_display #(.W(W), .N_DIGITS(N2), .CLK_DIV(CLK_DIV)) dut2 (
        .clk(clk), .rst(rst), .load(load2), .value(value2),
        .busy(busy2), .ovf(ovf2), .seg(seg2), .an(an2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles since reset release; the scan position is a pure function of this.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic int pow10(input int e);
        int p = 1;
        for (int i = 0; i < e; i++) p *= 10;
        return p;
    endfunction

    function automatic bit modelOvf(input int v, input int ndig);
        return v >= pow10(ndig);
    endfunction

    function automatic logic [6:0] modelSeg(input int v, input bit ovf_flag, input int d);
        if (ovf_flag) return 7'b1111110;
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
        if (d > 0 && v < pow10(d)) return 7'b1111111;
`endif
        return seg_table[(v / pow10(d)) % 10];
    endfunction

    function automatic logic [31:0] modelAn(input int ndig, input int d);
        return 32'(((1 << ndig) - 1) & ~(1 << d));
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_checks++;
        assert (obs === exp) passed_checks = passed_checks + 1;
        else begin
            failed_checks = failed_checks + 1;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit sel, input logic [W-1:0] v);
        if (sel) begin load2 = 1'b1; value2 = v; end
        else     begin load1 = 1'b1; value1 = v; end
        @(posedge clk);
        @(negedge clk);
        load1 = 1'b0;
        load2 = 1'b0;
    endtask

    task automatic waitBusy(input bit sel, output int cnt);
        cnt = 0;
        while ((sel ? busy2 : busy1) && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic checkScan(input int cycles);
        int d1, d2;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            d1 = ((cyc - 1) / CLK_DIV) % N1;
            d2 = ((cyc - 1) / CLK_DIV) % N2;
            checkOutput("an1_scan", 32'(an1), modelAn(N1, d1));
            checkOutput("seg1_scan", 32'(seg1), 32'(modelSeg(model_val1, model_ovf1, d1)));
            checkOutput("an2_scan", 32'(an2), modelAn(N2, d2));
            checkOutput("seg2_scan", 32'(seg2), 32'(modelSeg(model_val2, model_ovf2, d2)));
        end
    endtask

    initial begin
        rst = 1'b1; load1 = 1'b0; load2 = 1'b0; value1 = '0; value2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_an1", 32'(an1), 32'hF);
        checkOutput("reset_seg1", 32'(seg1), 32'h7F);
        checkOutput("reset_busy1", 32'(busy1), 32'h0);
        checkOutput("reset_ovf1", 32'(ovf1), 32'h0);
        checkOutput("reset_an2", 32'(an2), 32'h3);
        rst = 1'b0;

        $display("[TB] idle scan after reset");
        checkScan(20);

        $display("[TB] load 255 on 4-digit instance");
        applyStimulus(0, 8'd255);
        waitBusy(0, n);
        checkOutput("busy_len_255", 32'(n), 32'(W + 1));
        model_val1 = 255; model_ovf1 = modelOvf(255, N1);
        checkOutput("ovf_255", 32'(ovf1), 32'(model_ovf1));
        @(posedge clk);
        checkScan(16);

        $display("[TB] overflow then recovery on 2-digit instance");
        applyStimulus(1, 8'd123);
        waitBusy(1, n);
        checkOutput("busy_len_123", 32'(n), 32'(W + 1));
        model_val2 = 123; model_ovf2 = modelOvf(123, N2);
        checkOutput("ovf_123", 32'(ovf2), 32'(model_ovf2));
        @(posedge clk);
        checkScan(8);
        applyStimulus(1, 8'd42);
        waitBusy(1, n);
        model_val2 = 42; model_ovf2 = modelOvf(42, N2);
        checkOutput("ovf_42", 32'(ovf2), 32'(model_ovf2));
        @(posedge clk);
        checkScan(8);

        $display("[TB] load while busy is ignored");
        applyStimulus(0, 8'd7);
        @(negedge clk);
        applyStimulus(0, 8'd99);
        checkOutput("busy_during_ignored", 32'(busy1), 32'h1);
        waitBusy(0, n);
        checkOutput("busy_tail_ignored", 32'(n), 32'(W - 1));
        model_val1 = 7; model_ovf1 = modelOvf(7, N1);
        @(posedge clk);
        checkScan(16);

        $display("[TB] load on the cycle busy falls");
        applyStimulus(0, 8'd50);
        n = 0;
        while (busy1 && n < 40) begin n++; @(negedge clk); end
        checkOutput("busy_fall_seen", 32'(busy1), 32'h0);
        load1 = 1'b1; value1 = 8'd99;
        @(posedge clk);
        @(negedge clk);
        load1 = 1'b0;
        checkOutput("busy_after_fall_load", 32'(busy1), 32'h1);
        waitBusy(0, n);
        checkOutput("busy_len_99", 32'(n), 32'(W + 1));
        model_val1 = 99; model_ovf1 = modelOvf(99, N1);
        @(posedge clk);
        checkScan(16);

        $display("[TB] reset mid-conversion");
        value1 = $urandom_range(255, 200);
        applyStimulus(0, value1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_mid_busy", 32'(busy1), 32'h0);
        checkOutput("rst_mid_an", 32'(an1), 32'hF);
        checkOutput("rst_mid_seg", 32'(seg1), 32'h7F);
        checkOutput("rst_mid_ovf", 32'(ovf1), 32'h0);
        rst = 1'b0;
        model_val1 = 0; model_ovf1 = 0; model_val2 = 0; model_ovf2 = 0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("post_rst_an", 32'(an1), 32'hE);
        checkOutput("post_rst_seg", 32'(seg1), 32'(seg_table[0]));
        checkScan(12);

        $display("[TB] random loads");
        for (int r = 0; r < 4; r++) begin
            value1 = 8'($urandom_range(255, 0));
            value2 = 8'($urandom_range(255, 0));
            model_val1 = int'(value1); model_ovf1 = modelOvf(model_val1, N1);
            model_val2 = int'(value2); model_ovf2 = modelOvf(model_val2, N2);
            load1 = 1'b1; load2 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            load1 = 1'b0; load2 = 1'b0;
            waitBusy(0, n);
            checkOutput("busy_len_rand", 32'(n), 32'(W + 1));
            @(posedge clk);
            checkOutput("ovf1_rand", 32'(ovf1), 32'(model_ovf1));
            checkOutput("ovf2_rand", 32'(ovf2), 32'(model_ovf2));
            checkScan(16);
        end

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
